multi_rate_divider: RTL and testbench
=====================================

// Module: multi_rate_divider
// PURPOSE
//  Parametrised multi-channel clock-enable generator for the traffic-light controller.
//  - NUM_CH independent channels, each with a runtime-loadable divisor and mode.
//  - Each channel emits a one-cycle tick, a 50% duty level and a one-shot done flag.
//  - A small valid/ready config port loads the divisors.
//  - Replaces the fixed power-of-two 1 Hz divider; phase timers consume its ticks.
// PARAMETERS
//  CNT_W        30          counter/divisor width; max divisor 2^CNT_W-1
//  NUM_CH       2           number of channels (>=1)
//  DEFAULT_DIV  50_000_000  divisor loaded into every channel at reset (1 Hz @ 50 MHz)
//  CH_W         derived     max(1,$clog2(NUM_CH)); localparam, not overridable
// PORTS
//  clk              in   1       system clock, rising edge
//  divider_reset_n  in   1       asynchronous, active-low reset
//  run              in   1       global count enable; counters hold when 0
//  sync_clear       in   1       synchronous restart of all channels (cnt=0, re-arm)
//  cfg_valid        in   1       config request
//  cfg_ready        out  1       config accepted on an edge where valid&ready
//  cfg_ch           in   CH_W    target channel
//  cfg_div          in   CNT_W   new divisor; 0 is treated as 1
//  cfg_oneshot      in   1       0 = free-running, 1 = one-shot
//  tick             out  NUM_CH  one-cycle enable pulse per channel period
//  level            out  NUM_CH  toggles on every tick (period 2*div, exact 50%)
//  done             out  NUM_CH  one-shot channel has fired and is halted
// BEHAVIOUR
//  - Reset (async, immediate): cnt=0, div=DEFAULT_DIV, oneshot=0, armed=1,
//    tick=0, level=0, done=0, cfg FSM=IDLE, cfg_ready=1. All outputs are registered.
//  - Per-channel step, evaluated on each edge:
//    - If run=1 and armed: if cnt>=div-1 then cnt<=0, tick<=1, level<=~level;
//      otherwise cnt<=cnt+1, tick<=0.
//    - If run=0 or not armed: cnt holds, tick<=0.
//  - Timing: tick is high for the cycle after the div-th run=1 edge following
//    reset, clear or apply. Run-low cycles stretch the period one-for-one.
//  - div=1 (or cfg 0): tick stays high on every run cycle and level toggles every cycle.
//  - Comparison uses >=, so a stale cnt above div-1 wraps on the next run edge.
//  - One-shot: on the firing edge armed<=0 and done<=1. The channel then stays halted
//    (tick=0, level held) until sync_clear or a new config to that channel.
//  - sync_clear: all channels get cnt<=0, tick<=0, level<=0, done<=0, armed<=1.
//    div and mode are unchanged. sync_clear takes priority over the count step
//    in the same cycle.
//  - Config FSM: IDLE --(valid&ready)--> APPLY --> IDLE.
//    - IDLE: cfg_ready=1; cfg_ch, cfg_div, cfg_oneshot are captured into shadow
//      registers on accept.
//    - APPLY: cfg_ready=0 for exactly one cycle. At the end of APPLY the target
//      channel loads div and mode and clears as for sync_clear. Back-to-back
//      requests are accepted every 2 cycles.
//    - Other channels are never disturbed.
//    - cfg_ch>=NUM_CH: the handshake completes normally and the write is discarded.
//  - Simultaneous events:
//    - sync_clear during APPLY: both take effect; the target gets the new div, cleared.
//    - sync_clear and accept on the same edge: the accept is still taken.
//  - Reset mid-APPLY: the pending write is lost.
//  - Width: div and cnt are unsigned CNT_W. div-1 is computed after the 0->1 clamp,
//    so it never underflows.
// STRUCTURE
//  - Package divider_pkg holds:
//    - cfg_state_t enum {CFG_IDLE, CFG_APPLY}
//    - localparams DIV_FREE=1'b0, DIV_ONESHOT=1'b1
//  - Sub-module div_channel (cnt, div, mode, armed, tick, level, done). It is
//    instantiated NUM_CH times in a generate loop.
//  - The top level holds only the cfg FSM, the shadow registers and channel select.
// TESTING
//  - Reset, DEFAULT_DIV=4, NUM_CH=2, run=1 -> tick[0] and tick[1] high after edges
//    4, 8, 12; level rises at 4 and falls at 8; done=0.
//  - Cfg ch1 div=3 one-shot -> cfg_ready low 1 cycle; tick[1] once, 3 edges after
//    APPLY; done[1]=1; no tick in the next 20 cycles; sync_clear re-arms it.
//  - run low for 5 cycles mid-count with div=10 -> cnt holds; the next tick arrives
//    exactly 5 cycles late; level unaffected.
//  - Cfg div=0 then div=1 -> tick held high while run=1; level toggles every cycle.
//  - Drop divider_reset_n between edges mid-count -> tick, level, done go to 0
//    immediately and cfg_ready=1; count restarts from 0 with DEFAULT_DIV.
//  - sync_clear on the accept edge of cfg ch1 div=6 -> ch0 restarts, ch1 ticks 6 edges
//    after APPLY; cfg_ch=2 (NUM_CH=2) completes the handshake with no state change.

Source files
------------

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and mode constants for the multi-rate divider
package divider_pkg;

  typedef enum logic [0:0] {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cfg_state_t;

  localparam logic DIV_FREE    = 1'b0;
  localparam logic DIV_ONESHOT = 1'b1;

endpackage

// File: rtl/div_channel.sv
// rtl/div_channel.sv - one divider channel: counter, tick pulse, 50% level, one-shot done
module div_channel
  import divider_pkg::*;
#(
  parameter int CNT_W       = 30,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_oneshot,
  output logic             tick,
  output logic             level,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_DIV = (DEFAULT_DIV == 0) ? ONE : CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             mode;
  logic             armed;
  logic [CNT_W-1:0] div_m1;

  // div is held clamped to >=1, so this never underflows
  assign div_m1 = div - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div   <= DEF_DIV;
      mode  <= DIV_FREE;
      armed <= 1'b1;
      tick  <= 1'b0;
      level <= 1'b0;
      done  <= 1'b0;
    end else if (load || clear) begin
      if (load) begin
        div  <= (load_div == '0) ? ONE : load_div;
        mode <= load_oneshot;
      end
      cnt   <= '0;
      tick  <= 1'b0;
      level <= 1'b0;
      done  <= 1'b0;
      armed <= 1'b1;
    end else if (run && armed) begin
      if (cnt >= div_m1) begin
        cnt   <= '0;
        tick  <= 1'b1;
        level <= ~level;
        if (mode == DIV_ONESHOT) begin
          armed <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_rate_divider.sv
// rtl/multi_rate_divider.sv - config FSM, shadow registers and channel array
module multi_rate_divider
  import divider_pkg::*;
#(
  parameter int  CNT_W       = 30,
  parameter int  NUM_CH      = 2,
  parameter int  DEFAULT_DIV = 50_000_000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              divider_reset_n,
  input  logic              run,
  input  logic              sync_clear,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] done
);

  cfg_state_t       state;
  logic [CH_W-1:0]  sh_ch;
  logic [CNT_W-1:0] sh_div;
  logic             sh_oneshot;
  logic             accept;

  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge divider_reset_n) begin
    if (!divider_reset_n) begin
      state      <= CFG_IDLE;
      cfg_ready  <= 1'b1;
      sh_ch      <= '0;
      sh_div     <= '0;
      sh_oneshot <= DIV_FREE;
    end else if (state == CFG_IDLE) begin
      if (accept) begin
        state      <= CFG_APPLY;
        cfg_ready  <= 1'b0;
        sh_ch      <= cfg_ch;
        sh_div     <= cfg_div;
        sh_oneshot <= cfg_oneshot;
      end
    end else begin
      state     <= CFG_IDLE;
      cfg_ready <= 1'b1;
    end
  end

  // An out-of-range sh_ch matches no channel, so that write is simply dropped
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load;
    assign load = (state == CFG_APPLY) && (sh_ch == CH_W'(i));

    div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk         (clk),
      .rst_n       (divider_reset_n),
      .run         (run),
      .clear       (sync_clear),
      .load        (load),
      .load_div    (sh_div),
      .load_oneshot(sh_oneshot),
      .tick        (tick[i]),
      .level       (level[i]),
      .done        (done[i])
    );
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// tb/tb_multi_rate_divider.sv - vector table, directed corner sequences and random run vs reference model
module tb_multi_rate_divider;

  localparam int CNT_W       = 8;
  localparam int NUM_CH      = 3;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              sync_clear;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] done;

  always #5 clk = ~clk;

  multi_rate_divider #(
    .CNT_W      (CNT_W),
    .NUM_CH     (NUM_CH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk            (clk),
    .divider_reset_n(rst_n),
    .run            (run),
    .sync_clear     (sync_clear),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_ch         (cfg_ch),
    .cfg_div        (cfg_div),
    .cfg_oneshot    (cfg_oneshot),
    .tick           (tick),
    .level          (level),
    .done           (done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: each channel counts the run edges seen since its last restart
  int m_n   [NUM_CH];
  int m_d   [NUM_CH];
  bit m_os  [NUM_CH];
  bit m_tick[NUM_CH];
  bit m_pend;
  int m_sh_ch;
  int m_sh_div;
  bit m_sh_os;

  typedef struct {
    logic              r, c, v;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  dv;
    logic              o;
    logic [NUM_CH-1:0] et, el, ed;
    logic              er;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_n[k] = 0; m_d[k] = DEFAULT_DIV; m_os[k] = 1'b0; m_tick[k] = 1'b0;
    end
    m_pend = 1'b0;
  endfunction

  function automatic void model_edge(bit r, bit c, bit v, int ch, int dv, bit o);
    bit apply = m_pend;
    bit acc   = !m_pend && v;
    for (int k = 0; k < NUM_CH; k++) begin
      if (apply && m_sh_ch == k) begin
        m_d[k] = (m_sh_div == 0) ? 1 : m_sh_div;
        m_os[k] = m_sh_os; m_n[k] = 0; m_tick[k] = 1'b0;
      end else if (c) begin
        m_n[k] = 0; m_tick[k] = 1'b0;
      end else if (r && !(m_os[k] && m_n[k] >= m_d[k])) begin
        m_n[k]++;
        m_tick[k] = (m_n[k] % m_d[k]) == 0;
      end else begin
        m_tick[k] = 1'b0;
      end
    end
    if (apply) m_pend = 1'b0;
    if (acc) begin
      m_pend = 1'b1; m_sh_ch = ch; m_sh_div = dv; m_sh_os = o;
    end
  endfunction

  task automatic compare_model();
    logic [NUM_CH-1:0] et, el, ed;
    for (int k = 0; k < NUM_CH; k++) begin
      et[k] = m_tick[k];
      el[k] = ((m_n[k] / m_d[k]) % 2) == 1;
      ed[k] = m_os[k] && (m_n[k] >= m_d[k]);
    end
    check("model_tick",  32'(tick),      32'(et));
    check("model_level", 32'(level),     32'(el));
    check("model_done",  32'(done),      32'(ed));
    check("model_ready", 32'(cfg_ready), 32'(!m_pend));
  endtask

  task automatic step(input bit r, input bit c, input bit v, input int ch, input int dv, input bit o);
    run = r; sync_clear = c; cfg_valid = v;
    cfg_ch = CH_W'(ch); cfg_div = CNT_W'(dv); cfg_oneshot = o;
    @(posedge clk);
    model_edge(r, c, v, ch, dv, o);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    run = 1'b0; sync_clear = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
  endtask

  initial begin
    int first;
    logic prev;

    // r, c, v, ch, div, os | tick, level, done, ready   (ch2 mirrors ch0 throughout)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b111, 3'b111, 3'b000, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b111, 3'b111, 3'b000, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'd3, 1'b1, 3'b000, 3'b111, 3'b000, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b101, 3'b000, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b101, 3'b000, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b101, 3'b000, 3'b000, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b010, 3'b010, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset_tick",  32'(tick),      32'h0);
    check("reset_level", 32'(level),     32'h0);
    check("reset_done",  32'(done),      32'h0);
    check("reset_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].v, int'(tbl[i].ch), int'(tbl[i].dv), tbl[i].o);
      check($sformatf("tbl%0d_tick", i),  32'(tick),      32'(tbl[i].et));
      check($sformatf("tbl%0d_level", i), 32'(level),     32'(tbl[i].el));
      check($sformatf("tbl%0d_done", i),  32'(done),      32'(tbl[i].ed));
      check($sformatf("tbl%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].er));
    end

    // one-shot ch1 stays silent, then sync_clear re-arms it
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0, 0);
      check("oneshot_silent", 32'(tick[1]), 32'h0);
    end
    step(1, 1, 0, 0, 0, 0);
    check("clear_done", 32'(done), 32'h0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rearm_tick", 32'(tick[1]), 32'h1);

    // run-low gap stretches the period one-for-one
    step(1, 0, 1, 0, 10, 0);
    step(1, 0, 0, 0, 0, 0);
    first = -1;
    prev = level[0];
    for (int e = 1; e <= 30 && first < 0; e++) begin
      step(!(e >= 5 && e <= 9), 0, 0, 0, 0, 0);
      if (tick[0]) first = e;
      else check("gap_level_held", 32'(level[0]), 32'(prev));
    end
    check("gap_tick_edge", 32'(first), 32'd15);
    check("gap_level_rise", 32'(level[0]), 32'h1);

    // div=0 clamps to 1, then div=1: continuous tick, level toggles every cycle
    for (int d = 0; d < 2; d++) begin
      step(1, 0, 1, 0, d, 0);
      step(1, 0, 0, 0, 0, 0);
      prev = level[0];
      for (int i = 0; i < 5; i++) begin
        step(1, 0, 0, 0, 0, 0);
        check("div1_tick", 32'(tick[0]), 32'h1);
        check("div1_toggle", 32'(level[0]), 32'(!prev));
        prev = level[0];
      end
    end

    // async reset between edges during APPLY: outputs drop at once, write lost
    step(1, 0, 1, 1, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tick",  32'(tick),      32'h0);
    check("async_level", 32'(level),     32'h0);
    check("async_done",  32'(done),      32'h0);
    check("async_ready", 32'(cfg_ready), 32'h1);
    model_reset();
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 0, 0);
      check("post_reset_tick", 32'(tick), (i == 4) ? 32'h7 : 32'h0);
    end

    // sync_clear on the accept edge; accept still taken
    step(1, 1, 1, 1, 6, 0);
    check("clear_accept_ready", 32'(cfg_ready), 32'h0);
    step(1, 0, 0, 0, 0, 0);
    first = -1;
    for (int e = 1; e <= 12 && first < 0; e++) begin
      step(1, 0, 0, 0, 0, 0);
      if (tick[1]) first = e;
    end
    check("clear_accept_tick_edge", 32'(first), 32'd6);

    // out-of-range channel: handshake only
    step(1, 0, 1, 3, 1, 1);
    check("oor_ready_low", 32'(cfg_ready), 32'h0);
    step(1, 0, 0, 0, 0, 0);
    check("oor_ready_back", 32'(cfg_ready), 32'h1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
